// File: rtl/regfile_bypass8.sv
// 8 x WIDTH register file, two combinational read ports with same-cycle WB->ID bypass, one write port.
// Reads have zero latency, writes land on the rising edge, and the block never stalls its source.
module regfile_bypass8 #(
    parameter int WIDTH        = 16,
    parameter bit R0_HARDWIRED = 1'b0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [2:0]       RdReg1,
    input  logic [2:0]       RdReg2,
    input  logic [2:0]       WrReg,
    input  logic [WIDTH-1:0] WrData,
    input  logic             WrEn,
    output logic [WIDTH-1:0] RdData1,
    output logic [WIDTH-1:0] RdData2,
    output logic             Err
);

    logic [WIDTH-1:0] r_regs [8];
    logic             r_err;

    logic w_wr_r0_hw;
    logic w_wr_commit;
    logic w_byp1;
    logic w_byp2;
    logic w_zero1;
    logic w_zero2;

    assign w_wr_r0_hw  = R0_HARDWIRED && (WrReg == 3'd0);
    assign w_wr_commit = WrEn && !w_wr_r0_hw;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 8; i++) begin
                r_regs[i] <= '0;
            end
        end else if (w_wr_commit) begin
            r_regs[WrReg] <= WrData;
        end
    end

    // One-cycle pulse per dropped write to the hardwired zero register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_err <= 1'b0;
        end else begin
            r_err <= WrEn && w_wr_r0_hw;
        end
    end

    assign Err = r_err;

    // Hardwired-zero beats bypass; bypass is suppressed while in reset.
    assign w_zero1 = !rst_n || (R0_HARDWIRED && (RdReg1 == 3'd0));
    assign w_zero2 = !rst_n || (R0_HARDWIRED && (RdReg2 == 3'd0));
    assign w_byp1  = WrEn && (WrReg == RdReg1);
    assign w_byp2  = WrEn && (WrReg == RdReg2);

    always_comb begin
        RdData1 = r_regs[RdReg1];
        if (w_zero1) begin
            RdData1 = '0;
        end else if (w_byp1) begin
            RdData1 = WrData;
        end
    end

    always_comb begin
        RdData2 = r_regs[RdReg2];
        if (w_zero2) begin
            RdData2 = '0;
        end else if (w_byp2) begin
            RdData2 = WrData;
        end
    end

endmodule
